// File: rtl/mc_processor_core.sv
// Multi-cycle MIPS-subset core with one shared memory port using a req/ready handshake.
// A sequencing FSM steps through fetch, decode, execute, memory and writeback, and it traps on illegal encodings.
module mc_processor_core #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            Clk,
    input  logic            Rst,
    output logic            Mem_Req,
    output logic            Mem_We,
    output logic [XLEN-1:0] Mem_Addr,
    output logic [XLEN-1:0] Mem_WData,
    input  logic            Mem_Ready,
    input  logic [XLEN-1:0] Mem_RData,
    output logic            Retire,
    output logic [XLEN-1:0] Retire_PC,
    output logic            Trap
);

    localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic [31:0]     ir, ir_n;
    logic [XLEN-1:0] ir_pc, ir_pc_n;
    logic [XLEN-1:0] a, a_n, b, b_n;
    logic [XLEN-1:0] alu_out, alu_n;
    logic [XLEN-1:0] mdr, mdr_n;
    logic [XLEN-1:0] rf [NREGS];

    logic            rf_we;
    logic [RW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;

    logic            mem_req_n, mem_we_n, retire_n, trap_n;
    logic [XLEN-1:0] mem_addr_n, mem_wdata_n, retire_pc_n;

    // Instruction fields
    logic [5:0]      op, funct;
    logic [RW-1:0]   rs, rt, rd;
    logic [XLEN-1:0] imm;
    logic            legal;

    assign op    = ir[31:26];
    assign funct = ir[5:0];
    assign rs    = ir[21 +: RW];
    assign rt    = ir[16 +: RW];
    assign rd    = ir[11 +: RW];
    assign imm   = {{(XLEN-16){ir[15]}}, ir[15:0]};

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
                    default:                               legal = 1'b0;
                endcase
            end
            OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) state <= S_FETCH;
        else     state <= state_n;
    end

    // Next state, datapath updates and registered-output next values
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir;
        ir_pc_n     = ir_pc;
        a_n         = a;
        b_n         = b;
        alu_n       = alu_out;
        mdr_n       = mdr;
        rf_we       = 1'b0;
        rf_wa       = '0;
        rf_wd       = '0;
        retire_n    = 1'b0;
        mem_we_n    = Mem_We;
        mem_addr_n  = Mem_Addr;
        mem_wdata_n = Mem_WData;

        case (state)
            S_FETCH: begin
                if (Mem_Req && Mem_Ready) begin
                    ir_n    = Mem_RData[31:0];
                    ir_pc_n = pc;
                    pc_n    = pc + XLEN'(4);
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                a_n = rf[rs];
                b_n = rf[rt];
                if (!legal) begin
                    state_n = S_TRAP;
                end else if (op == OP_J) begin
                    pc_n     = {pc[XLEN-1:28], ir[25:0], 2'b00};
                    retire_n = 1'b1;
                    state_n  = S_FETCH;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_BEQ: begin
                        if (a == b) pc_n = pc + {imm[XLEN-3:0], 2'b00};
                        retire_n = 1'b1;
                        state_n  = S_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        alu_n   = a + imm;
                        state_n = S_MEM;
                    end
                    OP_ADDI: begin
                        alu_n   = a + imm;
                        state_n = S_WB;
                    end
                    default: begin
                        case (funct)
                            FN_SUB:  alu_n = a - b;
                            FN_AND:  alu_n = a & b;
                            FN_OR:   alu_n = a | b;
                            FN_SLT:  alu_n = XLEN'($signed(a) < $signed(b));
                            default: alu_n = a + b;
                        endcase
                        state_n = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                if (Mem_Req && Mem_Ready) begin
                    if (op == OP_SW) begin
                        retire_n = 1'b1;
                        state_n  = S_FETCH;
                    end else begin
                        mdr_n   = Mem_RData;
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wa    = (op == OP_RTYPE) ? rd : rt;
                rf_wd    = (op == OP_LW) ? mdr : alu_out;
                retire_n = 1'b1;
                state_n  = S_FETCH;
            end
            default: state_n = S_TRAP;
        endcase

        // Memory outputs follow the state being entered so they are valid on its first cycle
        mem_req_n = (state_n == S_FETCH) || (state_n == S_MEM);
        if (state_n == S_FETCH) begin
            mem_we_n   = 1'b0;
            mem_addr_n = pc_n;
        end else if (state_n == S_MEM) begin
            mem_we_n   = (op == OP_SW);
            mem_addr_n = alu_n;
            if (op == OP_SW) mem_wdata_n = b;
        end
        retire_pc_n = retire_n ? ir_pc : Retire_PC;
        trap_n      = (state_n == S_TRAP);
    end

    // Datapath, register file and output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc        <= PC_RESET;
            ir        <= '0;
            ir_pc     <= '0;
            a         <= '0;
            b         <= '0;
            alu_out   <= '0;
            mdr       <= '0;
            Mem_Req   <= 1'b0;
            Mem_We    <= 1'b0;
            Mem_Addr  <= '0;
            Mem_WData <= '0;
            Retire    <= 1'b0;
            Retire_PC <= '0;
            Trap      <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
        end else begin
            pc        <= pc_n;
            ir        <= ir_n;
            ir_pc     <= ir_pc_n;
            a         <= a_n;
            b         <= b_n;
            alu_out   <= alu_n;
            mdr       <= mdr_n;
            Mem_Req   <= mem_req_n;
            Mem_We    <= mem_we_n;
            Mem_Addr  <= mem_addr_n;
            Mem_WData <= mem_wdata_n;
            Retire    <= retire_n;
            Retire_PC <= retire_pc_n;
            Trap      <= trap_n;
            if (rf_we && (rf_wa != '0)) rf[rf_wa] <= rf_wd;
        end
    end

endmodule

// File: tb/tb_mc_processor_core.sv
// Directed self-checking bench for mc_processor_core: a 32-bit core on a wait-state memory model,
// plus a 64-bit instance that exercises PC wrap-around.
module tb_mc_processor_core;

    logic        Clk;
    logic        Rst;
    logic        mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, retire_pc;

    logic        rst64, req64, we64, ready64, retire64, trap64;
    logic [63:0] addr64, wdata64, rdata64, rpc64;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:255];
    int          wait_n = 0;
    int          wcnt = 0;
    logic [31:0] last_wa = 0, last_wd = 0;
    int          retire_cnt = 0;
    int          stab_checks = 0, stab_bad = 0;
    logic        p_req = 0, p_ready = 0, p_we = 0;
    logic [31:0] p_addr = 0, p_wdata = 0;

    mc_processor_core #(.XLEN(32), .NREGS(32), .PC_RESET(32'h0)) u_dut (
        .Clk(Clk), .Rst(Rst), .Mem_Req(mem_req), .Mem_We(mem_we), .Mem_Addr(mem_addr),
        .Mem_WData(mem_wdata), .Mem_Ready(mem_ready), .Mem_RData(mem_rdata),
        .Retire(retire), .Retire_PC(retire_pc), .Trap(trap)
    );

    mc_processor_core #(.XLEN(64), .NREGS(16), .PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) u_dut64 (
        .Clk(Clk), .Rst(rst64), .Mem_Req(req64), .Mem_We(we64), .Mem_Addr(addr64),
        .Mem_WData(wdata64), .Mem_Ready(ready64), .Mem_RData(rdata64),
        .Retire(retire64), .Retire_PC(rpc64), .Trap(trap64)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Memory model with a configurable number of wait cycles per access
    assign mem_ready = mem_req && (wcnt == wait_n);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge Clk) begin
        if (Rst || !mem_req || mem_ready) wcnt <= 0;
        else                              wcnt <= wcnt + 1;
        if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            last_wa = mem_addr;
            last_wd = mem_wdata;
        end
    end

    // 64-bit side: addi $1,$0,9 at the top word, j 0 everywhere else
    assign ready64 = req64;
    assign rdata64 = (addr64 == 64'hFFFF_FFFF_FFFF_FFFC) ? 64'h2001_0009 : 64'h0800_0000;

    // Retire counter and request-stability observer
    always @(negedge Clk) begin
        if (retire) retire_cnt = retire_cnt + 1;
        if (mem_req && p_req && !p_ready) begin
            stab_checks = stab_checks + 1;
            if (mem_addr !== p_addr || mem_wdata !== p_wdata || mem_we !== p_we)
                stab_bad = stab_bad + 1;
        end
        p_req   = mem_req;
        p_ready = mem_ready;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_wdata = mem_wdata;
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic wait_retire(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < budget) begin
            @(negedge Clk);
            cyc++;
            if (retire) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear_mem();
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        n_cmp++;
        if ({mem_req, mem_we, retire, trap} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 0000", {mem_req, mem_we, retire, trap});
        end
        n_cmp++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || retire_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_buses: got addr=%h wdata=%h rpc=%h expected all 0", mem_addr, mem_wdata, retire_pc);
        end
        Rst = 1'b0;
        @(negedge Clk);
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_first_fetch: got req=%b addr=%h expected req=1 addr=0", mem_req, mem_addr);
        end
    endtask

    task automatic test_alu_sequence();
        int cyc;
        bit ok;
        clear_mem();
        mem[0] = 32'h2001_0005;  // addi $1,$0,5
        mem[1] = 32'h2002_FFFD;  // addi $2,$0,-3
        mem[2] = 32'h0022_1820;  // add  $3,$1,$2
        mem[3] = 32'hAC03_0044;  // sw   $3,0x44($0)
        mem[4] = 32'h0800_0004;  // j    0x10
        wait_n = 0;
        do_reset();
        wait_retire(40, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h0) begin
            n_bad++;
            $display("FAIL alu_pc0: got ok=%0d pc=%h expected pc=00000000", ok, retire_pc);
        end
        for (int k = 1; k < 4; k++) begin
            wait_retire(40, cyc, ok);
            n_cmp++;
            if (!ok || retire_pc !== 32'(k * 4) || cyc != 4) begin
                n_bad++;
                $display("FAIL alu_step%0d: got ok=%0d pc=%h cycles=%0d expected pc=%h cycles=4",
                         k, ok, retire_pc, cyc, 32'(k * 4));
            end
        end
        n_cmp++;
        if (last_wa !== 32'h44 || last_wd !== 32'h2) begin
            n_bad++;
            $display("FAIL alu_add_result: got addr=%h data=%h expected addr=00000044 data=00000002", last_wa, last_wd);
        end
    endtask

    task automatic test_mem_wait();
        int cyc;
        bit ok;
        int sc0, sb0;
        clear_mem();
        mem[0] = 32'h2001_0005;  // addi $1,$0,5
        mem[1] = 32'hAC01_0040;  // sw   $1,0x40($0)
        mem[2] = 32'h8C04_0040;  // lw   $4,0x40($0)
        mem[3] = 32'hAC04_0048;  // sw   $4,0x48($0)
        mem[4] = 32'h0800_0004;  // j    0x10
        wait_n = 3;
        do_reset();
        sc0 = stab_checks;
        sb0 = stab_bad;
        wait_retire(80, cyc, ok);
        wait_retire(80, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h4 || cyc != 10) begin
            n_bad++;
            $display("FAIL wait_sw: got ok=%0d pc=%h cycles=%0d expected pc=00000004 cycles=10", ok, retire_pc, cyc);
        end
        n_cmp++;
        if (last_wa !== 32'h40 || last_wd !== 32'h5) begin
            n_bad++;
            $display("FAIL wait_sw_data: got addr=%h data=%h expected addr=00000040 data=00000005", last_wa, last_wd);
        end
        wait_retire(80, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h8 || cyc != 11) begin
            n_bad++;
            $display("FAIL wait_lw: got ok=%0d pc=%h cycles=%0d expected pc=00000008 cycles=11", ok, retire_pc, cyc);
        end
        wait_retire(80, cyc, ok);
        n_cmp++;
        if (!ok || mem[18] !== 32'h5) begin
            n_bad++;
            $display("FAIL wait_lw_value: got ok=%0d mem[0x48]=%h expected 00000005", ok, mem[18]);
        end
        n_cmp++;
        if (stab_checks - sc0 < 12 || stab_bad != sb0) begin
            n_bad++;
            $display("FAIL wait_stable: got checks=%0d unstable=%0d expected checks>=12 unstable=0",
                     stab_checks - sc0, stab_bad - sb0);
        end
        wait_n = 0;
    endtask

    task automatic test_branch();
        int cyc;
        bit ok;
        clear_mem();
        mem[0] = 32'h2001_0005;  // addi $1,$0,5
        mem[1] = 32'h2002_FFFD;  // addi $2,$0,-3
        mem[2] = 32'h0800_0004;  // j    0x10
        mem[4] = 32'h1021_FFFF;  // beq  $1,$1,-1
        do_reset();
        wait_retire(40, cyc, ok);
        wait_retire(40, cyc, ok);
        wait_retire(40, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h8 || cyc != 2) begin
            n_bad++;
            $display("FAIL br_j: got ok=%0d pc=%h cycles=%0d expected pc=00000008 cycles=2", ok, retire_pc, cyc);
        end
        wait_retire(40, cyc, ok);
        for (int k = 0; k < 3; k++) begin
            wait_retire(40, cyc, ok);
            n_cmp++;
            if (!ok || retire_pc !== 32'h10 || cyc != 3) begin
                n_bad++;
                $display("FAIL br_loop%0d: got ok=%0d pc=%h cycles=%0d expected pc=00000010 cycles=3",
                         k, ok, retire_pc, cyc);
            end
        end
        @(negedge Clk);
        n_cmp++;
        if (retire !== 1'b0 || retire_pc !== 32'h10) begin
            n_bad++;
            $display("FAIL br_pulse: got retire=%b pc=%h expected retire=0 pc=00000010", retire, retire_pc);
        end
        clear_mem();
        mem[0] = 32'h2001_0005;  // addi $1,$0,5
        mem[1] = 32'h1020_0003;  // beq  $1,$0,+3 (not taken)
        mem[2] = 32'h0800_0002;  // j    0x8
        do_reset();
        wait_retire(40, cyc, ok);
        wait_retire(40, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h4 || cyc != 3) begin
            n_bad++;
            $display("FAIL br_nt: got ok=%0d pc=%h cycles=%0d expected pc=00000004 cycles=3", ok, retire_pc, cyc);
        end
        wait_retire(40, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h8) begin
            n_bad++;
            $display("FAIL br_fallthru: got ok=%0d pc=%h expected pc=00000008", ok, retire_pc);
        end
    endtask

    task automatic test_alu_ops();
        int cyc;
        bit ok;
        clear_mem();
        mem[0]  = 32'h2001_0005;  // addi $1,$0,5
        mem[1]  = 32'h2002_FFFD;  // addi $2,$0,-3
        mem[2]  = 32'h0041_282A;  // slt  $5,$2,$1
        mem[3]  = 32'hAC05_0050;  // sw   $5,0x50
        mem[4]  = 32'h2000_0007;  // addi $0,$0,7
        mem[5]  = 32'hAC00_0054;  // sw   $0,0x54
        mem[6]  = 32'h0022_3022;  // sub  $6,$1,$2
        mem[7]  = 32'hAC06_0058;  // sw   $6,0x58
        mem[8]  = 32'h0022_3824;  // and  $7,$1,$2
        mem[9]  = 32'hAC07_005C;  // sw   $7,0x5C
        mem[10] = 32'h0022_4025;  // or   $8,$1,$2
        mem[11] = 32'hAC08_0060;  // sw   $8,0x60
        mem[12] = 32'h0022_482A;  // slt  $9,$1,$2
        mem[13] = 32'hAC09_0064;  // sw   $9,0x64
        mem[14] = 32'h0800_000E;  // j    0x38
        mem[21] = 32'h0000_DEAD;
        mem[25] = 32'h0000_FFFF;
        do_reset();
        ok = 1'b0;
        for (int k = 0; k < 15 && !(ok && retire_pc == 32'h38); k++) wait_retire(40, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h38) begin
            n_bad++;
            $display("FAIL ops_done: got ok=%0d pc=%h expected pc=00000038", ok, retire_pc);
        end
        n_cmp++;
        if (mem[20] !== 32'h1) begin
            n_bad++;
            $display("FAIL ops_slt_true: got %h expected 00000001", mem[20]);
        end
        n_cmp++;
        if (mem[21] !== 32'h0) begin
            n_bad++;
            $display("FAIL ops_r0: got %h expected 00000000", mem[21]);
        end
        n_cmp++;
        if (mem[22] !== 32'h8 || mem[23] !== 32'h5 || mem[24] !== 32'hFFFF_FFFD) begin
            n_bad++;
            $display("FAIL ops_sub_and_or: got %h %h %h expected 00000008 00000005 fffffffd",
                     mem[22], mem[23], mem[24]);
        end
        n_cmp++;
        if (mem[25] !== 32'h0) begin
            n_bad++;
            $display("FAIL ops_slt_false: got %h expected 00000000", mem[25]);
        end
    endtask

    task automatic test_trap();
        int rc0, budget, req_seen, ret_seen;
        clear_mem();
        mem[0] = 32'h2001_0005;
        for (int i = 1; i < 8; i++) mem[i] = 32'h2021_0001;  // addi $1,$1,1
        mem[8] = 32'hFC00_0000;                              // opcode 0x3F
        do_reset();
        rc0 = retire_cnt;
        budget = 0;
        while (!trap && budget < 200) begin
            @(negedge Clk);
            budget++;
        end
        n_cmp++;
        if (trap !== 1'b1 || retire_cnt - rc0 != 8 || retire_pc !== 32'h1C) begin
            n_bad++;
            $display("FAIL trap_set: got trap=%b retires=%0d pc=%h expected trap=1 retires=8 pc=0000001c",
                     trap, retire_cnt - rc0, retire_pc);
        end
        req_seen = 0;
        ret_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (mem_req) req_seen++;
            if (retire) ret_seen++;
        end
        n_cmp++;
        if (req_seen != 0 || ret_seen != 0 || trap !== 1'b1) begin
            n_bad++;
            $display("FAIL trap_quiet: got req=%0d retire=%0d trap=%b expected 0 0 1", req_seen, ret_seen, trap);
        end
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        n_cmp++;
        if (trap !== 1'b0) begin
            n_bad++;
            $display("FAIL trap_clear: got %b expected 0", trap);
        end
        budget = 0;
        while (!mem_req && budget < 5) begin
            @(negedge Clk);
            budget++;
        end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL trap_refetch: got req=%b addr=%h expected req=1 addr=00000000", mem_req, mem_addr);
        end
        // Illegal funct under a legal R-type opcode also traps without retiring
        clear_mem();
        mem[0] = 32'h0000_003F;
        do_reset();
        rc0 = retire_cnt;
        repeat (8) @(negedge Clk);
        n_cmp++;
        if (trap !== 1'b1 || retire_cnt != rc0) begin
            n_bad++;
            $display("FAIL trap_funct: got trap=%b retires=%0d expected trap=1 retires=0", trap, retire_cnt - rc0);
        end
    endtask

    task automatic test_reset_mid_access();
        int cyc, budget;
        bit ok;
        clear_mem();
        mem[0]  = 32'h2004_0009;  // addi $4,$0,9
        mem[1]  = 32'h8C04_0044;  // lw   $4,0x44($0)
        mem[2]  = 32'h0800_0002;  // j    0x8
        mem[17] = 32'h0000_0077;
        wait_n = 3;
        do_reset();
        budget = 0;
        while (!(mem_req && !mem_we && mem_addr == 32'h44) && budget < 100) begin
            @(negedge Clk);
            budget++;
        end
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
            n_bad++;
            $display("FAIL mid_reach_lw: got req=%b addr=%h expected req=1 addr=00000044", mem_req, mem_addr);
        end
        Rst = 1'b1;
        @(negedge Clk);
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_req_drop: got %b expected 0", mem_req);
        end
        clear_mem();
        mem[0]  = 32'hAC04_0048;  // sw $4,0x48($0)
        mem[1]  = 32'h0800_0001;  // j  0x4
        mem[18] = 32'h0000_AAAA;
        Rst = 1'b0;
        wait_retire(60, cyc, ok);
        n_cmp++;
        if (!ok || retire_pc !== 32'h0 || mem[18] !== 32'h0) begin
            n_bad++;
            $display("FAIL mid_no_wb: got ok=%0d pc=%h stored=%h expected pc=00000000 stored=00000000",
                     ok, retire_pc, mem[18]);
        end
        wait_n = 0;
    endtask

    task automatic test_xlen64_wrap();
        int budget;
        rst64 = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        rst64 = 1'b0;
        budget = 0;
        while (!retire64 && budget < 20) begin
            @(negedge Clk);
            budget++;
        end
        n_cmp++;
        if (retire64 !== 1'b1 || rpc64 !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_bad++;
            $display("FAIL x64_retire: got retire=%b pc=%h expected retire=1 pc=fffffffffffffffc", retire64, rpc64);
        end
        n_cmp++;
        if (req64 !== 1'b1 || addr64 !== 64'h0) begin
            n_bad++;
            $display("FAIL x64_wrap: got req=%b addr=%h expected req=1 addr=0", req64, addr64);
        end
        @(negedge Clk);
        budget = 0;
        while (!retire64 && budget < 20) begin
            @(negedge Clk);
            budget++;
        end
        n_cmp++;
        if (retire64 !== 1'b1 || rpc64 !== 64'h0 || trap64 !== 1'b0) begin
            n_bad++;
            $display("FAIL x64_next: got retire=%b pc=%h trap=%b expected retire=1 pc=0 trap=0",
                     retire64, rpc64, trap64);
        end
    endtask

    initial begin
        Rst   = 1'b1;
        rst64 = 1'b1;
        test_reset();
        test_alu_sequence();
        test_mem_wait();
        test_branch();
        test_alu_ops();
        test_trap();
        test_reset_mid_access();
        test_xlen64_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
